// File: rtl/fp_arith_pkg.sv
// Shared definitions for the floating-point arithmetic helpers.
//   sub_state_t  : control states of the digit-serial subtractor
//   DEF_WIDTH    : default operand width
//   DEF_DIGIT    : default bits processed per cycle
//   num_digits() : number of slices per operand
//   cnt_width()  : width of the slice counter
package fp_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DIGIT = 4;

    function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // A single-slice operand still needs a 1-bit counter to stay a legal vector.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
        int unsigned n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_sub_slice.sv
// Combinational DIGIT-bit borrow-chain subtractor: d = x - y - bin.
//   x, y : slice operands
//   bin  : borrow in from the less significant slice
//   d    : slice difference
//   bout : borrow out to the more significant slice
module digit_sub_slice
    import fp_arith_pkg::*;
#(
    parameter int unsigned DIGIT = DEF_DIGIT
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] br;

    assign br[0] = bin;

    // One full subtractor per bit; borrow ripples upward.
    for (genvar i = 0; i < DIGIT; i++) begin : g_fs
        assign d[i]    = x[i] ^ y[i] ^ br[i];
        assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end

    assign bout = br[DIGIT];

endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, one DIGIT slice per clock, LSB slice first.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake for a (minuend) and b (subtrahend)
//   out_valid/out_ready : result handshake
//   diff                : (a - b) mod 2^WIDTH
//   borrow              : 1 iff a < b unsigned
//   zero                : diff == 0
//   ovf                 : signed overflow of a - b
module digit_serial_subtractor
    import fp_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned NUM_DIGITS = num_digits(WIDTH, DIGIT);
    localparam int unsigned CNT_W      = cnt_width(WIDTH, DIGIT);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("digit_serial_subtractor: WIDTH must be a multiple of DIGIT");
    end

    sub_state_t             state, state_n;
    logic [WIDTH-1:0]       a_sh, b_sh, res_sh;
    logic                   borrow_reg;
    logic [CNT_W-1:0]       count;
    logic                   sign_a, sign_b;
    logic                   accept, step, last;
    logic [DIGIT-1:0]       slice_d;
    logic                   slice_bout;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;

    digit_sub_slice #(.DIGIT(DIGIT)) u_slice (
        .x    (a_sh[DIGIT-1:0]),
        .y    (b_sh[DIGIT-1:0]),
        .bin  (borrow_reg),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // New slice enters at the top; after NUM_DIGITS steps the word is aligned.
    assign res_cat  = {slice_d, res_sh};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and datapath enables.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == CNT_W'(NUM_DIGITS - 1)) begin
                    last    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow     <= 1'b0;
            zero       <= 1'b0;
            ovf        <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            borrow_reg <= 1'b0;
            count      <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
        end else begin
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
            if (accept) begin
                a_sh       <= a;
                b_sh       <= b;
                res_sh     <= '0;
                borrow_reg <= 1'b0;
                count      <= '0;
                sign_a     <= a[WIDTH-1];
                sign_b     <= b[WIDTH-1];
            end
            if (step) begin
                a_sh       <= a_sh >> DIGIT;
                b_sh       <= b_sh >> DIGIT;
                res_sh     <= res_next;
                borrow_reg <= slice_bout;
                count      <= count + CNT_W'(1);
            end
            // Flags are frozen here and held through DONE.
            if (last) begin
                diff   <= res_next;
                borrow <= slice_bout;
                zero   <= (res_next == '0);
                ovf    <= (sign_a != sign_b) && (res_next[WIDTH-1] != sign_a);
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Self-checking bench for digit_serial_subtractor (WIDTH=16, DIGIT=4).
module tb_digit_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    digit_serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] d, output logic br,
                         output logic z, output logic o);
        int sd;
        d  = x - y;
        br = (x < y);
        z  = (d == 16'h0000);
        sd = int'($signed(x)) - int'($signed(y));
        o  = (sd > 32767) || (sd < -32768);
    endtask

    task automatic check_result(input string tag, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] ed;
        logic eb, ez, eo;
        model(x, y, ed, eb, ez, eo);
        check({tag, "_diff"},   32'(diff),   32'(ed));
        check({tag, "_borrow"}, 32'(borrow), 32'(eb));
        check({tag, "_zero"},   32'(zero),   32'(ez));
        check({tag, "_ovf"},    32'(ovf),    32'(eo));
    endtask

    // One directed operation: accept, measure latency, check, optional stall, retire.
    task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input int hold, input bit chg);
        int n;
        bit ok_run;
        out_ready = (hold == 0);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (chg) begin
            a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
        end
        n = 0;
        ok_run = 1'b1;
        while (!out_valid && n < 20) begin
            if (in_ready) ok_run = 1'b0;
            tick();
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_in_ready_run"}, 32'(ok_run), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'd4);
        check_result(tag, x, y);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check_result({tag, "_hold"}, x, y);
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 3; i++) if (out_valid) n++;
        tick();
        check({tag, "_no_second"}, 32'(out_valid), 32'd0);
    endtask

    logic [18:0] sb_q[$];
    int          n_sent;
    int          n_recv;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_flags", 32'({borrow, zero, ovf}), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        do_op("basic", 16'h1234, 16'h0234, 0, 1'b0);
        do_op("neg", 16'h0000, 16'h0001, 0, 1'b0);
        do_op("ovf", 16'h8000, 16'h0001, 0, 1'b0);
        do_op("equal", 16'hBEEF, 16'hBEEF, 0, 1'b1);
        do_op("stall", 16'h0100, 16'h0001, 6, 1'b0);

        // Reset during the second RUN cycle.
        begin
            int seen;
            out_ready = 1'b1;
            a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            rst = 1'b1;
            #1;
            check("abort_in_ready", 32'(in_ready), 32'd1);
            check("abort_out_valid", 32'(out_valid), 32'd0);
            check("abort_diff", 32'(diff), 32'd0);
            check("abort_flags", 32'({borrow, zero, ovf}), 32'd0);
            tick();
            rst = 1'b0;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (out_valid) seen++;
            end
            check("abort_no_result", 32'(seen), 32'd0);
        end
        do_op("after_abort", 16'h0005, 16'h0003, 0, 1'b0);

        // Random stream with random handshake gaps.
        n_sent = 0;
        n_recv = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    bit acc;
                    int guard;
                    logic [15:0] ed;
                    logic eb, ez, eo;
                    in_valid = 1'b0;
                    a = 16'($urandom); b = 16'($urandom);
                    repeat ($urandom_range(0, 3)) tick();
                    a = 16'($urandom); b = 16'($urandom);
                    if (i % 5 == 0) b = a;
                    in_valid = 1'b1;
                    acc = 1'b0;
                    guard = 0;
                    while (!acc && guard < 100) begin
                        acc = in_ready;
                        if (acc) begin
                            model(a, b, ed, eb, ez, eo);
                            sb_q.push_back({ed, eb, ez, eo});
                            n_sent++;
                        end
                        tick();
                        guard++;
                    end
                    in_valid = 1'b0;
                    if (!acc) check("rand_accept_timeout", 32'd0, 32'd1);
                end
            end
            begin
                int cyc;
                logic [18:0] exp;
                cyc = 0;
                while (n_recv < 20 && cyc < 3000) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_valid && out_ready) begin
                        if (sb_q.size() == 0) begin
                            check("rand_spurious", 32'd1, 32'd0);
                        end else begin
                            exp = sb_q.pop_front();
                            check("rand_result", 32'({diff, borrow, zero, ovf}), 32'(exp));
                        end
                        n_recv++;
                    end
                    tick();
                    cyc++;
                end
            end
        join
        check("rand_count", 32'(n_recv), 32'(n_sent));
        check("rand_sent", 32'(n_sent), 32'd20);
        out_ready = 1'b1;
        repeat (8) tick();
        check("rand_drain", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
